pipelined_barrel_shifter: RTL and testbench

Parametrised, pipelined successor to the combinational 2-bit logic shifter. Shifts an N-bit word left or right by 0..N-1 positions in logical, arithmetic or rotate mode, one log2 stage per pipeline register, with valid/ready flow control and a lost-bits flag. It sits in the datapath library as the registered shifter for ALU and normaliser blocks that need full throughput at high clock rates.

---
 rtl/pipelined_barrel_shifter.sv | 100 ++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined N-bit barrel shifter: one power-of-two shift stage per register,
// logical/arithmetic/rotate modes, whole-pipe valid/ready stall, lost-bit flag.
module pipelined_barrel_shifter #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  data_in,
    input  logic [SW-1:0] shift_amount,
    input  logic          direction,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  data_out,
    output logic          data_lost
);

    localparam int L = SW;

    typedef struct packed {
        logic          valid;
        logic          dir;
        logic [1:0]    mode;
        logic          sign;
        logic [SW-1:0] shamt;
        logic          lost;
        logic [N-1:0]  data;
    } stage_t;

    stage_t stage_q  [L];
    stage_t stage_d  [L];
    stage_t stage_in [L];
    logic   [N:0] step;
    logic         advance;

    // Shift by a fixed power of two; returns {bits discarded, result}.
    // Rotate never discards; mode 11 falls through to the logical paths.
    function automatic logic [N:0] shift_step(input stage_t s, input int amt);
        logic [N-1:0] ones;
        logic [N-1:0] res;
        logic         lost;
        ones = '1;
        lost = 1'b0;
        if (s.mode == 2'b10) begin
            res = s.dir ? ((s.data >> amt) | (s.data << (N - amt)))
                        : ((s.data << amt) | (s.data >> (N - amt)));
        end else if (s.dir) begin
            res  = s.data >> amt;
            if (s.mode == 2'b01 && s.sign) res = res | ~(ones >> amt);
            lost = |(s.data << (N - amt));
        end else begin
            res  = s.data << amt;
            lost = |(s.data >> (N - amt));
        end
        return {lost, res};
    endfunction

    assign advance  = !stage_q[L-1].valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        // NOTE: every always_comb target gets a full default first so no latch is inferred.
        step              = '0;
        stage_in[0].valid = in_valid;
        stage_in[0].dir   = direction;
        stage_in[0].mode  = mode;
        stage_in[0].sign  = data_in[N-1];
        stage_in[0].shamt = shift_amount;
        stage_in[0].lost  = 1'b0;
        stage_in[0].data  = data_in;
        for (int k = 1; k < L; k++) stage_in[k] = stage_q[k-1];
        for (int k = 0; k < L; k++) begin
            stage_d[k] = stage_in[k];
            if (stage_in[k].shamt[k]) begin
                step             = shift_step(stage_in[k], 1 << k);
                stage_d[k].data  = step[N-1:0];
                stage_d[k].lost  = stage_in[k].lost | step[N];
            end
        end
    end

    // The sign of the operand travels with the beat so arithmetic fill is
    // always the entry MSB, not whatever sits in the top bit mid-pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            for (int k = 0; k < L; k++) stage_q[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k < L; k++) stage_q[k] <= stage_d[k];
        end
    end

    assign out_valid = stage_q[L-1].valid;
    assign data_out  = stage_q[L-1].data;
    assign data_lost = stage_q[L-1].lost;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed vector table at N=8,
// backpressure and mid-flight reset sequences, and an exhaustive N=2 replay.
module tb_pipelined_barrel_shifter;

    typedef struct {
        logic [7:0] data;
        logic [2:0] shamt;
        logic       dir;
        logic [1:0] mode;
        logic [7:0] exp_data;
        logic       exp_lost;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, direction, data_lost;
    logic [7:0] data_in, data_out;
    logic [2:0] shift_amount;
    logic [1:0] mode;

    logic       in_valid_2, in_ready_2, out_valid_2, out_ready_2, direction_2, data_lost_2;
    logic [1:0] data_in_2, data_out_2, mode_2;
    logic [0:0] shift_amount_2;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[16];

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_amount(shift_amount), .direction(direction),
        .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .data_lost(data_lost)
    );

    pipelined_barrel_shifter #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_2), .in_ready(in_ready_2),
        .data_in(data_in_2), .shift_amount(shift_amount_2), .direction(direction_2),
        .mode(mode_2), .out_valid(out_valid_2), .out_ready(out_ready_2),
        .data_out(data_out_2), .data_lost(data_lost_2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one beat into an otherwise idle pipe and measure its latency in edges,
    // counting the acceptance edge as the first.
    task automatic run_vec(input vec_t v, input string name);
        int lat;
        in_valid     = 1'b1;
        data_in      = v.data;
        shift_amount = v.shamt;
        direction    = v.dir;
        mode         = v.mode;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, " latency"}, lat, 3);
        check({name, " data"}, data_out, v.exp_data);
        check({name, " lost"}, data_lost, v.exp_lost);
    endtask

    int         next_in, next_out, stall_left, cyc, stale;
    logic       seen, acc_in, acc_out;
    logic [7:0] held;
    logic [1:0] d2, e2;
    logic       sh2, dr2, l2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //            data          sh    dir   mode   expected      lost
        vecs[0]  = '{8'b1011_0001, 3'd3, 1'b0, 2'b00, 8'b1000_1000, 1'b1};
        vecs[1]  = '{8'b1001_0000, 3'd2, 1'b1, 2'b01, 8'b1110_0100, 1'b0};
        vecs[2]  = '{8'b0111_1111, 3'd7, 1'b1, 2'b01, 8'b0000_0000, 1'b1};
        vecs[3]  = '{8'b0000_0011, 3'd1, 1'b1, 2'b10, 8'b1000_0001, 1'b0};
        vecs[4]  = '{8'b1000_0001, 3'd1, 1'b0, 2'b10, 8'b0000_0011, 1'b0};
        vecs[5]  = '{8'b1010_0101, 3'd0, 1'b0, 2'b00, 8'b1010_0101, 1'b0};
        vecs[6]  = '{8'b1010_0101, 3'd0, 1'b1, 2'b01, 8'b1010_0101, 1'b0};
        vecs[7]  = '{8'b1111_0000, 3'd4, 1'b1, 2'b00, 8'b0000_1111, 1'b0};
        vecs[8]  = '{8'b1111_0001, 3'd4, 1'b1, 2'b00, 8'b0000_1111, 1'b1};
        vecs[9]  = '{8'b1100_0011, 3'd2, 1'b0, 2'b11, 8'b0000_1100, 1'b1};
        vecs[10] = '{8'b1000_0000, 3'd7, 1'b1, 2'b01, 8'b1111_1111, 1'b0};
        vecs[11] = '{8'b1000_0001, 3'd2, 1'b1, 2'b01, 8'b1110_0000, 1'b1};
        vecs[12] = '{8'b1011_0001, 3'd3, 1'b0, 2'b10, 8'b1000_1101, 1'b0};
        vecs[13] = '{8'b0110_1001, 3'd5, 1'b1, 2'b10, 8'b0100_1011, 1'b0};
        vecs[14] = '{8'b1000_0001, 3'd1, 1'b0, 2'b01, 8'b0000_0010, 1'b1};
        vecs[15] = '{8'b0000_0001, 3'd1, 1'b1, 2'b11, 8'b0000_0000, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; data_in = '0; shift_amount = '0; direction = 1'b0; mode = '0;
        out_ready = 1'b1;
        in_valid_2 = 1'b0; data_in_2 = '0; shift_amount_2 = '0; direction_2 = 1'b0;
        mode_2 = '0; out_ready_2 = 1'b1;

        repeat (3) tick();
        check("reset out_valid", out_valid, 0);
        check("reset data_out", data_out, 0);
        check("reset data_lost", data_lost, 0);
        check("reset out_valid n2", out_valid_2, 0);
        rst = 1'b0;
        tick();
        check("in_ready after release", in_ready, 1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: five back-to-back beats, output stalled 4 cycles.
        tick();
        next_in = 0; next_out = 0; stall_left = 0; cyc = 0; seen = 1'b0; held = '0;
        shift_amount = 3'd1; direction = 1'b0; mode = 2'b00;
        while (next_out < 5 && cyc < 60) begin
            if (!seen && out_valid) begin
                seen = 1'b1;
                stall_left = 4;
                held = data_out;
            end
            out_ready = (stall_left == 0);
            in_valid  = (next_in < 5);
            data_in   = 8'(next_in + 1);
            #1;
            if (stall_left > 0) begin
                check("stall in_ready", in_ready, 0);
                check("stall out_valid", out_valid, 1);
                check("stall data held", data_out, held);
                stall_left--;
            end
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                check($sformatf("bp result%0d", next_out), data_out, 2 * (next_out + 1));
                next_out++;
            end
            if (acc_in) next_in++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp beats accepted", next_in, 5);
        check("bp beats delivered", next_out, 5);
        check("bp stall seen", seen, 1);
        stale = 0;
        repeat (4) begin
            if (out_valid) stale++;
            tick();
        end
        check("bp no duplicate", stale, 0);

        // Reset with three beats in flight.
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; data_in = 8'hF1 - 8'(b); shift_amount = 3'd3;
            direction = 1'b0; mode = 2'b00;
            tick();
        end
        in_valid = 1'b0;
        check("pre-reset out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async reset out_valid", out_valid, 0);
        check("async reset data_out", data_out, 0);
        check("async reset data_lost", data_lost, 0);
        tick();
        tick();
        rst = 1'b0;
        stale = 0;
        repeat (6) begin
            tick();
            if (out_valid) stale++;
        end
        check("no stale beat after reset", stale, 0);
        check("in_ready after reset", in_ready, 1);
        run_vec(vecs[0], "post-reset");

        // N=2, single stage: every data/shift/direction combination, logical mode.
        for (int i = 0; i < 16; i++) begin
            d2  = i[1:0];
            sh2 = i[2];
            dr2 = i[3];
            in_valid_2 = 1'b1; data_in_2 = d2; shift_amount_2 = sh2; direction_2 = dr2;
            mode_2 = 2'b00;
            tick();
            e2 = !sh2 ? d2 : (dr2 ? {1'b0, d2[1]} : {d2[0], 1'b0});
            l2 = sh2 && (dr2 ? d2[0] : d2[1]);
            check($sformatf("n2 valid %0d", i), out_valid_2, 1);
            check($sformatf("n2 data %0d", i), data_out_2, e2);
            check($sformatf("n2 lost %0d", i), data_lost_2, l2);
        end
        in_valid_2 = 1'b0;
        tick();
        check("n2 drains", out_valid_2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
